// File: rtl/decode_stage_pipe_pkg.sv
// Shared types and field positions for the decode stage.
// Instruction layout: cond | op | i | cmd | rd | rn | imm13 (rs in low nibble).
package decode_stage_pipe_pkg;

  localparam int N_DEF  = 32;
  localparam int RA_DEF = 4;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 29;
  localparam int OP_HI    = 28;
  localparam int OP_LO    = 27;
  localparam int I_BIT    = 26;
  localparam int CMD_HI   = 25;
  localparam int CMD_LO   = 21;
  localparam int RD_HI    = 20;
  localparam int RD_LO    = 17;
  localparam int RN_HI    = 16;
  localparam int RN_LO    = 13;
  localparam int RS_HI    = 3;
  localparam int RS_LO    = 0;
  localparam int IMM13_HI = 12;
  localparam int IMM26_HI = 25;

  typedef enum logic {
    IMM_DP13 = 1'b0,
    IMM_BR26 = 1'b1
  } imm_src_t;

  typedef struct packed {
    logic [N_DEF-1:0]  rd1;
    logic [N_DEF-1:0]  rd2;
    logic [N_DEF-1:0]  imm;
    logic [N_DEF-1:0]  pc;
    logic [RA_DEF-1:0] rd;
    logic [2:0]        cond;
    logic [4:0]        cmd;
    logic [1:0]        op;
    logic              i;
    logic              mem_to_reg;
  } ex_payload_t;

endpackage

// File: rtl/decode_stage_pipe_reg_file.sv
// Two-read/one-write register file with PC injection on the top
// address and write-through bypass from the writeback port.
module reg_file_bypass #(
  parameter int RA = 4,
  parameter int N  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RA-1:0] ra1_i,
  input  logic [RA-1:0] ra2_i,
  output logic [N-1:0]  rd1_o,
  output logic [N-1:0]  rd2_o,
  input  logic          we_i,
  input  logic [RA-1:0] wa_i,
  input  logic [N-1:0]  wd_i,
  input  logic [N-1:0]  pc_i,
  output logic [N-1:0]  dbg_r0_o,
  output logic [N-1:0]  dbg_r1_o
);

  localparam int NR = 2**RA;
  localparam logic [RA-1:0] PC_A = {RA{1'b1}};

  logic [N-1:0] regs_q [NR];
  logic         wr_ok;

  assign wr_ok = we_i && (wa_i != PC_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) regs_q[k] <= '0;
    end else if (wr_ok) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // PC address wins over bypass: it is never a real register
  assign rd1_o = (ra1_i == PC_A)             ? pc_i :
                 (wr_ok && wa_i == ra1_i)    ? wd_i :
                                               regs_q[ra1_i];
  assign rd2_o = (ra2_i == PC_A)             ? pc_i :
                 (wr_ok && wa_i == ra2_i)    ? wd_i :
                                               regs_q[ra2_i];

  assign dbg_r0_o = regs_q[0];
  assign dbg_r1_o = regs_q[1];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: field split, register read, immediate extend and the
// registered decode->execute stage with stall/flush/load-use control.
module decode_stage_pipe
  import decode_stage_pipe_pkg::*;
#(
  parameter int N     = 32,
  parameter int RA    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [N-1:0]     if_pc,
  output logic             id_ready,
  output logic [4:0]       hdr_cmd,
  output logic [1:0]       hdr_op,
  output logic             hdr_i,
  output logic [RA-1:0]    hdr_rd,
  input  logic             ctl_reg_src_a1,
  input  logic             ctl_reg_src_a2,
  input  logic             ctl_imm_src,
  input  logic             ctl_mem_to_reg,
  input  logic             wb_we,
  input  logic [RA-1:0]    wb_addr,
  input  logic [N-1:0]     wb_data,
  input  logic             ex_stall,
  input  logic             ex_flush,
  output logic             ex_valid,
  output logic [N-1:0]     ex_rd1,
  output logic [N-1:0]     ex_rd2,
  output logic [N-1:0]     ex_imm,
  output logic [N-1:0]     ex_pc,
  output logic [RA-1:0]    ex_rd,
  output logic [2:0]       ex_cond,
  output logic [4:0]       ex_cmd,
  output logic [1:0]       ex_op,
  output logic             ex_i,
  output logic             ex_mem_to_reg,
  output logic [N-1:0]     dbg_r0,
  output logic [N-1:0]     dbg_r1,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [N-1:0]  rd1;
    logic [N-1:0]  rd2;
    logic [N-1:0]  imm;
    logic [N-1:0]  pc;
    logic [RA-1:0] rd;
    logic [2:0]    cond;
    logic [4:0]    cmd;
    logic [1:0]    op;
    logic          i;
    logic          mem_to_reg;
  } stage_t;

  stage_t           dec, ex_d, ex_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [RA-1:0]    rn, rs, rd, a1, a2;
  logic [N-1:0]     rd1, rd2, imm;
  logic             load_use;
  imm_src_t         isrc;

  assign rn = RA'(if_inst[RN_HI:RN_LO]);
  assign rs = RA'(if_inst[RS_HI:RS_LO]);
  assign rd = RA'(if_inst[RD_HI:RD_LO]);
  assign a1 = ctl_reg_src_a1 ? {RA{1'b1}} : rn;
  assign a2 = ctl_reg_src_a2 ? rd : rs;

  assign hdr_cmd = if_inst[CMD_HI:CMD_LO];
  assign hdr_op  = if_inst[OP_HI:OP_LO];
  assign hdr_i   = if_inst[I_BIT];
  assign hdr_rd  = rd;

  reg_file_bypass #(.RA(RA), .N(N)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1_i    (a1),
    .ra2_i    (a2),
    .rd1_o    (rd1),
    .rd2_o    (rd2),
    .we_i     (wb_we),
    .wa_i     (wb_addr),
    .wd_i     (wb_data),
    .pc_i     (if_pc),
    .dbg_r0_o (dbg_r0),
    .dbg_r1_o (dbg_r1)
  );

  assign isrc = imm_src_t'(ctl_imm_src);

  always_comb begin
    imm = '0;
    unique case (isrc)
      IMM_BR26: imm = N'($signed(if_inst[IMM26_HI:0]));
      IMM_DP13: imm = N'(if_inst[IMM13_HI:0]);
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.rd1        = rd1;
    dec.rd2        = rd2;
    dec.imm        = imm;
    dec.pc         = if_pc;
    dec.rd         = rd;
    dec.cond       = if_inst[COND_HI:COND_LO];
    dec.cmd        = if_inst[CMD_HI:CMD_LO];
    dec.op         = if_inst[OP_HI:OP_LO];
    dec.i          = if_inst[I_BIT];
    dec.mem_to_reg = ctl_mem_to_reg;
  end

  assign load_use = valid_q & ex_q.mem_to_reg & if_valid &
                    ((ex_q.rd == a1) | (ex_q.rd == a2));

  assign id_ready = ex_flush | ~(ex_stall | load_use);

  // Priority: flush > stall > load-use bubble > normal issue
  always_comb begin
    ex_d    = dec;
    valid_d = if_valid;
    cnt_d   = cnt_q;
    if (ex_flush) begin
      valid_d = 1'b0;
    end else if (ex_stall) begin
      ex_d    = ex_q;
      valid_d = valid_q;
    end else if (load_use) begin
      valid_d = 1'b0;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_rd1        = ex_q.rd1;
  assign ex_rd2        = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_cond       = ex_q.cond;
  assign ex_cmd        = ex_q.cmd;
  assign ex_op         = ex_q.op;
  assign ex_i          = ex_q.i;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: vector table with a
// scoreboard queue, plus hazard/stall/flush/saturation/reset sequences.
module tb_decode_stage_pipe;
  import decode_stage_pipe_pkg::*;

  localparam int N  = 32;
  localparam int RA = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [N-1:0]  if_pc;
  logic          id_ready;
  logic [4:0]    hdr_cmd;
  logic [1:0]    hdr_op;
  logic          hdr_i;
  logic [RA-1:0] hdr_rd;
  logic          ctl_reg_src_a1, ctl_reg_src_a2;
  logic          ctl_imm_src, ctl_mem_to_reg;
  logic          wb_we;
  logic [RA-1:0] wb_addr;
  logic [N-1:0]  wb_data;
  logic          ex_stall, ex_flush;
  logic          ex_valid;
  logic [N-1:0]  ex_rd1, ex_rd2, ex_imm, ex_pc;
  logic [RA-1:0] ex_rd;
  logic [2:0]    ex_cond;
  logic [4:0]    ex_cmd;
  logic [1:0]    ex_op;
  logic          ex_i, ex_mem_to_reg;
  logic [N-1:0]  dbg_r0, dbg_r1;
  logic [CW-1:0] stall_cnt;

  decode_stage_pipe #(.N(N), .RA(RA), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready),
    .hdr_cmd(hdr_cmd), .hdr_op(hdr_op), .hdr_i(hdr_i), .hdr_rd(hdr_rd),
    .ctl_reg_src_a1(ctl_reg_src_a1), .ctl_reg_src_a2(ctl_reg_src_a2),
    .ctl_imm_src(ctl_imm_src), .ctl_mem_to_reg(ctl_mem_to_reg),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_stall(ex_stall), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_cond(ex_cond),
    .ex_cmd(ex_cmd), .ex_op(ex_op), .ex_i(ex_i),
    .ex_mem_to_reg(ex_mem_to_reg),
    .dbg_r0(dbg_r0), .dbg_r1(dbg_r1), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   inst;
    logic [N-1:0]  pc;
    logic          a1, a2, isrc, m2r;
    logic          we;
    logic [RA-1:0] wa;
    logic [N-1:0]  wd;
    logic [N-1:0]  e1, e2, ei;
  } vec_t;

  typedef struct packed {
    logic        v;
    ex_payload_t p;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [7];
  exp_t sbq [$];

  function automatic logic [31:0] mk(
    input logic [2:0] cond, input logic [1:0] op, input logic i,
    input logic [4:0] cmd, input logic [3:0] rd, input logic [3:0] rn,
    input logic [12:0] lo);
    return {cond, op, i, cmd, rd, rn, lo};
  endfunction

  function automatic vec_t mkv(
    input logic [31:0] inst, input logic [N-1:0] pc,
    input logic a1, input logic a2, input logic isrc, input logic m2r,
    input logic we, input logic [RA-1:0] wa, input logic [N-1:0] wd,
    input logic [N-1:0] e1, input logic [N-1:0] e2,
    input logic [N-1:0] ei);
    vec_t v;
    v.inst = inst; v.pc = pc; v.a1 = a1; v.a2 = a2;
    v.isrc = isrc; v.m2r = m2r; v.we = we; v.wa = wa; v.wd = wd;
    v.e1 = e1; v.e2 = e2; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_valid       = 1'b1;
    if_inst        = v.inst;
    if_pc          = v.pc;
    ctl_reg_src_a1 = v.a1;
    ctl_reg_src_a2 = v.a2;
    ctl_imm_src    = v.isrc;
    ctl_mem_to_reg = v.m2r;
    wb_we          = v.we;
    wb_addr        = v.wa;
    wb_data        = v.wd;
  endtask

  task automatic push_exp(input vec_t v, input logic valid);
    exp_t e;
    e.v            = valid;
    e.p.rd1        = v.e1;
    e.p.rd2        = v.e2;
    e.p.imm        = v.ei;
    e.p.pc         = v.pc;
    e.p.rd         = v.inst[20:17];
    e.p.cond       = v.inst[31:29];
    e.p.cmd        = v.inst[25:21];
    e.p.op         = v.inst[28:27];
    e.p.i          = v.inst[26];
    e.p.mem_to_reg = v.m2r;
    sbq.push_back(e);
  endtask

  task automatic cmp_out(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty got %0d want 1", tag, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, ".valid"}, 32'(ex_valid), 32'(e.v));
    chk({tag, ".rd1"}, ex_rd1, e.p.rd1);
    chk({tag, ".rd2"}, ex_rd2, e.p.rd2);
    chk({tag, ".imm"}, ex_imm, e.p.imm);
    chk({tag, ".pc"}, ex_pc, e.p.pc);
    chk({tag, ".rd"}, 32'(ex_rd), 32'(e.p.rd));
    chk({tag, ".cond"}, 32'(ex_cond), 32'(e.p.cond));
    chk({tag, ".cmd"}, 32'(ex_cmd), 32'(e.p.cmd));
    chk({tag, ".op"}, 32'(ex_op), 32'(e.p.op));
    chk({tag, ".i"}, 32'(ex_i), 32'(e.p.i));
    chk({tag, ".m2r"}, 32'(ex_mem_to_reg), 32'(e.p.mem_to_reg));
  endtask

  task automatic wb_wr(input logic [RA-1:0] a, input logic [N-1:0] d);
    if_valid = 1'b0;
    wb_we    = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(negedge clk);
    wb_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got %0d want %0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t ld, dp, sf;

    rst_n = 1'b0;
    if_valid = 1'b0; if_inst = '0; if_pc = '0;
    ctl_reg_src_a1 = 1'b0; ctl_reg_src_a2 = 1'b0;
    ctl_imm_src = 1'b0; ctl_mem_to_reg = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ex_stall = 1'b0; ex_flush = 1'b0;

    vecs[0] = mkv(mk(3'd3, 2'd1, 1'b0, 5'd5, 4'd1, 4'd2, 13'h0003),
                  32'h10, 0, 0, 0, 0, 0, 4'd0, 32'h0,
                  32'h5, 32'h7, 32'h3);
    vecs[1] = mkv(mk(3'd0, 2'd0, 1'b1, 5'd0, 4'd0, 4'd2, 13'h0003),
                  32'h14, 0, 0, 0, 0, 1, 4'd3, 32'hAA,
                  32'h5, 32'hAA, 32'h3);
    vecs[2] = mkv(mk(3'd0, 2'd2, 1'b0, 5'd9, 4'd0, 4'd0, 13'h0003),
                  32'h100, 1, 0, 0, 0, 1, 4'd15, 32'hDEAD,
                  32'h100, 32'hAA, 32'h3);
    vecs[3] = mkv(mk(3'd7, 2'd3, 1'b1, 5'd31, 4'd2, 4'd0, 13'h0000),
                  32'h200, 1, 1, 0, 0, 0, 4'd0, 32'h0,
                  32'h200, 32'h5, 32'h0);
    vecs[4] = mkv(32'h03FF_FFFE, 32'h300, 0, 0, 1, 0, 0, 4'd0, 32'h0,
                  32'h300, 32'h0, 32'hFFFF_FFFE);
    vecs[5] = mkv(32'h0000_1FFF, 32'h400, 0, 0, 0, 0, 0, 4'd0, 32'h0,
                  32'h0, 32'h400, 32'h0000_1FFF);
    vecs[6] = mkv(mk(3'd0, 2'd0, 1'b0, 5'd0, 4'd0, 4'd0, 13'h0002),
                  32'h500, 0, 0, 0, 0, 1, 4'd0, 32'h1234,
                  32'h1234, 32'h5, 32'h2);

    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", 32'(ex_valid), 32'd0);
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    chk("rst.ready", 32'(id_ready), 32'd1);
    chk("rst.rd1", ex_rd1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    wb_wr(4'd2, 32'h5);
    wb_wr(4'd3, 32'h7);

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      push_exp(vecs[i], 1'b1);
      #1;
      chk($sformatf("v%0d.ready", i), 32'(id_ready), 32'd1);
      chk($sformatf("v%0d.hcmd", i), 32'(hdr_cmd), 32'(vecs[i].inst[25:21]));
      chk($sformatf("v%0d.hrd", i), 32'(hdr_rd), 32'(vecs[i].inst[20:17]));
      @(negedge clk);
      cmp_out($sformatf("v%0d", i));
    end
    chk("dbg.r0", dbg_r0, 32'h1234);
    chk("dbg.r1", dbg_r1, 32'h0);

    // load-use bubble then issue
    ld = mkv(mk(3'd0, 2'd0, 1'b0, 5'd1, 4'd4, 4'd0, 13'h0000),
             32'h600, 0, 0, 0, 1, 0, 4'd0, 32'h0,
             32'h1234, 32'h1234, 32'h0);
    dp = mkv(mk(3'd0, 2'd0, 1'b0, 5'd2, 4'd5, 4'd4, 13'h0003),
             32'h604, 0, 0, 0, 0, 0, 4'd0, 32'h0,
             32'h0, 32'hAA, 32'h3);
    drive(ld);
    push_exp(ld, 1'b1);
    @(negedge clk);
    cmp_out("ld");
    drive(dp);
    #1;
    chk("lu.ready", 32'(id_ready), 32'd0);
    @(negedge clk);
    chk("lu.bubble", 32'(ex_valid), 32'd0);
    chk("lu.cnt", 32'(stall_cnt), 32'd1);
    chk("lu.ready2", 32'(id_ready), 32'd1);
    push_exp(dp, 1'b1);
    @(negedge clk);
    cmp_out("lu.issue");

    // stall holds for 3 cycles, then flush overrides stall
    ex_stall = 1'b1;
    drive(vecs[0]);
    for (int k = 0; k < 3; k++) begin
      push_exp(dp, 1'b1);
      #1;
      chk($sformatf("st%0d.ready", k), 32'(id_ready), 32'd0);
      @(negedge clk);
      cmp_out($sformatf("st%0d", k));
    end
    ex_flush = 1'b1;
    #1;
    chk("fl.ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("fl.valid", 32'(ex_valid), 32'd0);
    ex_stall = 1'b0;
    ex_flush = 1'b0;

    // flush beats load-use and the counter holds
    drive(ld);
    @(negedge clk);
    chk("fl2.ld", 32'(ex_valid), 32'd1);
    drive(dp);
    ex_flush = 1'b1;
    #1;
    chk("fl2.ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    chk("fl2.valid", 32'(ex_valid), 32'd0);
    chk("fl2.cnt", 32'(stall_cnt), 32'd1);
    ex_flush = 1'b0;

    // self-dependent load: one bubble every two cycles
    sf = mkv(mk(3'd0, 2'd0, 1'b0, 5'd3, 4'd4, 4'd4, 13'h0000),
             32'h700, 0, 0, 0, 1, 0, 4'd0, 32'h0,
             32'h0, 32'h0, 32'h0);
    drive(sf);
    for (int c = 1; c <= 2 * ((1 << CW) + 3); c++) begin
      @(negedge clk);
      if (c == 6)  chk("sat.c6", 32'(stall_cnt), 32'd4);
      if (c == 26) chk("sat.c26", 32'(stall_cnt), 32'd14);
      if (c == 30) chk("sat.c30", 32'(stall_cnt), 32'd15);
    end
    chk("sat.end", 32'(stall_cnt), 32'hF);
    @(negedge clk);
    chk("pre.valid", 32'(ex_valid), 32'd1);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.cnt", 32'(stall_cnt), 32'd0);
    chk("arst.rd", 32'(ex_rd), 32'd0);
    chk("arst.pc", ex_pc, 32'd0);
    chk("arst.m2r", 32'(ex_mem_to_reg), 32'd0);
    chk("arst.r0", dbg_r0, 32'd0);
    if_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post.valid", 32'(ex_valid), 32'd0);
    chk("post.cnt", 32'(stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
